// File: rtl/hazard_pkg.sv
// Shared definitions for the D-stage hazard scoreboard: stage indices,
// forward-select encoding and the scoreboard entry layout.
package hazard_pkg;

    localparam int STG_E  = 0;
    localparam int STG_M  = 1;
    localparam int STG_W  = 2;
    localparam int FWD_RF = 0;

    localparam int REG_AW = 5;
    localparam int REG_TW = 2;

    typedef struct packed {
        logic              valid;
        logic [REG_AW-1:0] dst;
        logic [REG_TW-1:0] tnew;
    } sb_entry_t;

    localparam int ENTRY_W = $bits(sb_entry_t);

    // Forward select must encode "regfile" plus one code per tracked stage.
    function automatic int sel_width(input int nstage);
        return $clog2(nstage + 1);
    endfunction

endpackage

// File: rtl/hazard_src_match.sv
// Per-source lookup against the in-flight writer scoreboard: youngest
// matching writer decides both the hazard and the forward select.
module hazard_src_match
    import hazard_pkg::*;
#(
    parameter int NSTAGE = 3,
    parameter int AW     = 5,
    parameter int TW     = 2,
    parameter int SW     = 2
) (
    input  logic [AW-1:0]        src_addr,
    input  logic [TW-1:0]        tuse,
    input  logic [NSTAGE-1:0]    ent_valid,
    input  logic [NSTAGE*AW-1:0] ent_dst,
    input  logic [NSTAGE*TW-1:0] ent_tnew,
    output logic                 hazard,
    output logic [SW-1:0]        fwd_sel
);

    logic          hit;
    logic [TW-1:0] hit_tnew;
    logic [SW-1:0] hit_stage;
    logic          src_hit;

    always_comb begin
        hit       = 1'b0;
        hit_tnew  = '0;
        hit_stage = '0;
        // Walk from oldest to youngest so the youngest match overwrites.
        for (int k = NSTAGE - 1; k >= 0; k--) begin
            if (ent_valid[k] && (ent_dst[k*AW +: AW] == src_addr)) begin
                hit       = 1'b1;
                hit_tnew  = ent_tnew[k*TW +: TW];
                hit_stage = SW'(k + 1);
            end
        end
    end

    assign src_hit = (src_addr != '0) && hit;
    assign hazard  = src_hit && (hit_tnew > tuse);
    assign fwd_sel = (src_hit && (hit_tnew == '0)) ? hit_stage : SW'(FWD_RF);

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage stall/forward controller: self-aging scoreboard of writers in
// E..W, MDU busy countdown and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter  int NSRC     = 2,
    parameter  int NSTAGE   = 3,
    parameter  int AW       = 5,
    parameter  int TW       = 2,
    parameter  int MULT_LAT = 5,
    parameter  int DIV_LAT  = 10,
    parameter  int CNTW     = 32,
    localparam int SW       = sel_width(NSTAGE)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 id_valid,
    input  logic [NSRC*AW-1:0]   id_src_addr,
    input  logic [NSRC*TW-1:0]   id_tuse,
    input  logic [AW-1:0]        id_dst_addr,
    input  logic                 id_reg_we,
    input  logic [TW-1:0]        id_tnew,
    input  logic                 id_mdu_start,
    input  logic                 id_mdu_div,
    input  logic                 id_mdu_req,
    input  logic                 flush,
    output logic                 stall,
    output logic [NSRC*SW-1:0]   fwd_sel,
    output logic                 mdu_busy,
    output logic [CNTW-1:0]      stall_cnt
);

    localparam int MDU_MAX = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int MW      = $clog2(MDU_MAX + 1);

    logic [NSTAGE-1:0]    ent_valid;
    logic [NSTAGE*AW-1:0] ent_dst;
    logic [NSTAGE*TW-1:0] ent_tnew;
    logic [MW-1:0]        mdu_cnt;
    logic [NSRC-1:0]      src_hazard;
    logic                 issue_wr;
    logic                 mdu_accept;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        hazard_src_match #(
            .NSTAGE (NSTAGE),
            .AW     (AW),
            .TW     (TW),
            .SW     (SW)
        ) u_match (
            .src_addr  (id_src_addr[i*AW +: AW]),
            .tuse      (id_tuse[i*TW +: TW]),
            .ent_valid (ent_valid),
            .ent_dst   (ent_dst),
            .ent_tnew  (ent_tnew),
            .hazard    (src_hazard[i]),
            .fwd_sel   (fwd_sel[i*SW +: SW])
        );
    end

    assign mdu_busy   = (mdu_cnt != '0);
    assign stall      = id_valid && ((|src_hazard) || ((id_mdu_req || id_mdu_start) && mdu_busy));
    assign issue_wr   = id_valid && id_reg_we && (id_dst_addr != '0) && !stall;
    assign mdu_accept = id_valid && id_mdu_start && !stall;

    // Entries age by one stage per cycle; a stalled D inserts a bubble in E.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_valid <= '0;
            ent_dst   <= '0;
            ent_tnew  <= '0;
        end else begin
            ent_valid[STG_E]         <= issue_wr && !flush;
            ent_dst[STG_E*AW +: AW]  <= id_dst_addr;
            ent_tnew[STG_E*TW +: TW] <= id_tnew;
            for (int k = 1; k < NSTAGE; k++) begin
                ent_valid[k]         <= ent_valid[k-1] && !flush;
                ent_dst[k*AW +: AW]  <= ent_dst[(k-1)*AW +: AW];
                ent_tnew[k*TW +: TW] <= (ent_tnew[(k-1)*TW +: TW] == '0) ? '0
                                        : ent_tnew[(k-1)*TW +: TW] - 1'b1;
            end
        end
    end

    // MDU ops cannot be cancelled, so flush leaves the countdown alone.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mdu_cnt <= '0;
        end else if (mdu_accept) begin
            mdu_cnt <= id_mdu_div ? MW'(DIV_LAT) : MW'(MULT_LAT);
        end else if (mdu_cnt != '0) begin
            mdu_cnt <= mdu_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scenario bench for hazard_scoreboard: each row's expected outputs are queued
// as it is driven and compared half a cycle later.
module tb_hazard_scoreboard;

    localparam int NSRC   = 2;
    localparam int NSTAGE = 3;
    localparam int AW     = 5;
    localparam int TW     = 2;
    localparam int SW     = 2;
    localparam int CNTW   = 4;

    logic                 clk = 1'b0;
    logic                 reset;
    logic                 id_valid;
    logic [NSRC*AW-1:0]   id_src_addr;
    logic [NSRC*TW-1:0]   id_tuse;
    logic [AW-1:0]        id_dst_addr;
    logic                 id_reg_we;
    logic [TW-1:0]        id_tnew;
    logic                 id_mdu_start;
    logic                 id_mdu_div;
    logic                 id_mdu_req;
    logic                 flush;
    logic                 stall;
    logic [NSRC*SW-1:0]   fwd_sel;
    logic                 mdu_busy;
    logic [CNTW-1:0]      stall_cnt;

    hazard_scoreboard #(
        .NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW), .TW(TW),
        .MULT_LAT(5), .DIV_LAT(10), .CNTW(CNTW)
    ) dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_src_addr(id_src_addr),
        .id_tuse(id_tuse), .id_dst_addr(id_dst_addr), .id_reg_we(id_reg_we),
        .id_tnew(id_tnew), .id_mdu_start(id_mdu_start), .id_mdu_div(id_mdu_div),
        .id_mdu_req(id_mdu_req), .flush(flush), .stall(stall), .fwd_sel(fwd_sel),
        .mdu_busy(mdu_busy), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [4:0] s0;
        logic [1:0] u0;
        logic [4:0] s1;
        logic [1:0] u1;
        logic [4:0] d;
        logic       we;
        logic [1:0] tn;
        logic       ms, md, mr, fl;
        logic       x_stall;
        logic [1:0] x_f0, x_f1;
        logic       x_busy;
    } row_t;

    typedef struct {
        logic       stall;
        logic [1:0] f0, f1;
        logic       busy;
    } exp_t;

    exp_t            sb[$];
    int              errors = 0;
    int              checks = 0;
    logic [CNTW-1:0] exp_cnt = '0;

    function automatic row_t mk(input int v, input int s0, input int u0, input int s1, input int u1,
                                input int d, input int we, input int tn,
                                input int ms, input int md, input int mr, input int fl,
                                input int xs, input int xf0, input int xf1, input int xb);
        row_t r;
        r.v = 1'(v);   r.s0 = 5'(s0); r.u0 = 2'(u0); r.s1 = 5'(s1); r.u1 = 2'(u1);
        r.d = 5'(d);   r.we = 1'(we); r.tn = 2'(tn);
        r.ms = 1'(ms); r.md = 1'(md); r.mr = 1'(mr); r.fl = 1'(fl);
        r.x_stall = 1'(xs); r.x_f0 = 2'(xf0); r.x_f1 = 2'(xf1); r.x_busy = 1'(xb);
        return r;
    endfunction

    task automatic drive(input row_t r);
        exp_t e;
        id_valid     = r.v;
        id_src_addr  = {r.s1, r.s0};
        id_tuse      = {r.u1, r.u0};
        id_dst_addr  = r.d;
        id_reg_we    = r.we;
        id_tnew      = r.tn;
        id_mdu_start = r.ms;
        id_mdu_div   = r.md;
        id_mdu_req   = r.mr;
        flush        = r.fl;
        e.stall = r.x_stall; e.f0 = r.x_f0; e.f1 = r.x_f1; e.busy = r.x_busy;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        drive(mk(0, 0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
        void'(sb.pop_back());
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(0);
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({stall, fwd_sel, mdu_busy, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_idle: got stall=%b fwd=%h busy=%b cnt=%0d, want all zero",
                     stall, fwd_sel, mdu_busy, stall_cnt);
        end
        id_valid = 1'b1; id_src_addr = {5'd8, 5'd8};
        #1;
        checks++;
        if ({stall, fwd_sel} !== '0) begin
            errors++;
            $display("FAIL reset_read: got stall=%b fwd=%h, want stall=0 fwd=0", stall, fwd_sel);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        idle(1);
    endtask

    task automatic test_load_use();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0, 0,0, 8,1,2, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 8,0, 8,0, 9,1,1, 0,0,0,0, 1,0,0,0));
        rows.push_back(mk(1, 8,0, 8,0, 9,1,1, 0,0,0,0, 1,0,0,0));
        rows.push_back(mk(1, 8,0, 8,0, 9,1,1, 0,0,0,0, 0,3,3,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL load_use[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_store_fwd();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0,  0,0, 8,1,1, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 29,1, 8,2, 0,0,0, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 8,0,  0,0, 0,0,0, 0,0,0,0, 0,2,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL store_fwd[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_youngest_wins();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0, 0,0, 8,1,1,  0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 0,0, 0,0, 8,1,1,  0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 8,0, 8,1, 11,1,1, 0,0,0,0, 1,0,0,0));
        rows.push_back(mk(1, 8,0, 8,1, 11,1,1, 0,0,0,0, 0,2,2,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL youngest[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_mdu();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0, 0,0, 0,0,0, 1,1,1,0, 0,0,0,0));
        repeat (10) rows.push_back(mk(1, 0,0, 0,0, 10,1,1, 0,0,1,0, 1,0,0,1));
        rows.push_back(mk(1, 0,0, 0,0, 10,1,1, 0,0,1,0, 0,0,0,0));
        rows.push_back(mk(1, 0,0, 0,0, 0,0,0, 1,0,1,0, 0,0,0,0));
        repeat (5) rows.push_back(mk(1, 0,0, 0,0, 12,1,1, 0,0,1,0, 1,0,0,1));
        rows.push_back(mk(1, 0,0, 0,0, 12,1,1, 0,0,1,0, 0,0,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL mdu[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(4);
        checks++;
        if (stall_cnt !== 4'hf) begin
            errors++;
            $display("FAIL stall_cnt_sat: got %0d want 15", stall_cnt);
        end
    endtask

    task automatic test_flush();
        row_t rows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0, 0,0, 8,1,2, 0,0,0,0, 0,0,0,0));
        rows.push_back(mk(1, 8,0, 0,0, 0,0,0, 0,0,0,1, 1,0,0,0));
        rows.push_back(mk(1, 8,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL flush[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_reset_mid_op();
        row_t rows[$];
        row_t zrows[$];
        exp_t e;
        rows.push_back(mk(1, 0,0, 0,0, 0,0,0, 1,1,1,0, 0,0,0,0));
        rows.push_back(mk(1, 0,0, 0,0, 8,1,2, 0,0,0,0, 0,0,0,1));
        rows.push_back(mk(1, 8,0, 0,0, 9,1,1, 0,0,1,0, 1,0,0,1));
        foreach (rows[i]) begin
            drive(rows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL mid_op[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        checks++;
        if ({stall, mdu_busy} !== 2'b11) begin
            errors++;
            $display("FAIL pre_reset: got stall=%b busy=%b, want stall=1 busy=1", stall, mdu_busy);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({stall, fwd_sel, mdu_busy, stall_cnt} !== '0) begin
            errors++;
            $display("FAIL async_reset: got stall=%b fwd=%h busy=%b cnt=%0d, want all zero",
                     stall, fwd_sel, mdu_busy, stall_cnt);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_cnt = '0;
        @(posedge clk); #1;
        zrows.push_back(mk(1, 0,0, 0,0, 0,1,2, 0,0,0,0, 0,0,0,0));
        zrows.push_back(mk(1, 0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
        zrows.push_back(mk(1, 0,0, 0,0, 0,0,0, 0,0,0,0, 0,0,0,0));
        foreach (zrows[i]) begin
            drive(zrows[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if ({stall, fwd_sel, mdu_busy, stall_cnt} !== {e.stall, e.f1, e.f0, e.busy, exp_cnt}) begin
                errors++;
                $display("FAIL zero_src[%0d]: got stall=%b fwd=%h busy=%b cnt=%0d, want stall=%b fwd=%h busy=%b cnt=%0d",
                         i, stall, fwd_sel, mdu_busy, stall_cnt, e.stall, {e.f1, e.f0}, e.busy, exp_cnt);
            end
            if (e.stall && exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
            @(posedge clk); #1;
        end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_store_fwd();
        test_youngest_wins();
        test_mdu();
        test_flush();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
